// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: passes ALU results through to WB and runs a
// request/acknowledge data-RAM transaction for loads and stores.
module mem_lsu #(
    parameter int ADDR_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int MAX_WAIT   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic [REG_ADDR_W-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic [31:0]           wdata_i,
    input  logic                  whilo_i,
    input  logic [31:0]           hi_i,
    input  logic [31:0]           lo_i,
    input  logic [3:0]            mem_op_i,
    input  logic [ADDR_W-1:0]     mem_addr_i,
    input  logic [31:0]           mem_sdata_i,
    output logic                  stall_req_o,
    output logic                  valid_o,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o,
    output logic [31:0]           wdata_o,
    output logic                  whilo_o,
    output logic [31:0]           hi_o,
    output logic [31:0]           lo_o,
    output logic                  align_err_o,
    output logic                  bus_err_o,
    output logic                  ram_req_o,
    output logic                  ram_we_o,
    output logic [ADDR_W-1:0]     ram_addr_o,
    output logic [3:0]            ram_sel_o,
    output logic [31:0]           ram_wdata_o,
    input  logic [31:0]           ram_rdata_i,
    input  logic                  ram_ack_i
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_e;

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [3:0]            op_q, op_d;
    logic [1:0]            off_q, off_d;
    logic                  valid_q, valid_d;
    logic [REG_ADDR_W-1:0] wd_q, wd_d;
    logic                  wreg_q, wreg_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  whilo_q, whilo_d;
    logic [31:0]           hi_q, hi_d;
    logic [31:0]           lo_q, lo_d;
    logic                  align_q, align_d;
    logic                  bus_q, bus_d;
    logic                  ram_req_q, ram_req_d;
    logic                  ram_we_q, ram_we_d;
    logic [ADDR_W-1:0]     ram_addr_q, ram_addr_d;
    logic [3:0]            ram_sel_q, ram_sel_d;
    logic [31:0]           ram_wdata_q, ram_wdata_d;

    logic is_load, is_store, is_mem, misaligned, accept_mem, timeout;
    logic [7:0]  load_byte;
    logic [15:0] load_half;

    assign is_load    = (mem_op_i >= OP_LB) && (mem_op_i <= OP_LW);
    assign is_store   = (mem_op_i >= OP_SB) && (mem_op_i <= OP_SW);
    assign is_mem     = is_load || is_store;
    assign misaligned = (((mem_op_i == OP_LH) || (mem_op_i == OP_LHU) || (mem_op_i == OP_SH))
                         && mem_addr_i[0])
                     || (((mem_op_i == OP_LW) || (mem_op_i == OP_SW))
                         && (mem_addr_i[1:0] != 2'b00));
    assign accept_mem = (state_q == IDLE) && valid_i && is_mem && !misaligned;
    // Ack wins over timeout when both land in the final allowed cycle.
    assign timeout    = (state_q == ACCESS) && !ram_ack_i && (cnt_q == CNT_W'(MAX_WAIT));

    assign load_byte = ram_rdata_i[{off_q, 3'b000} +: 8];
    assign load_half = ram_rdata_i[{off_q[1], 4'b0000} +: 16];

    // NOTE: sequential state uses non-blocking assignments only; every flop,
    // datapath holding registers included, is cleared by the async reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            off_q       <= '0;
            valid_q     <= 1'b0;
            wd_q        <= '0;
            wreg_q      <= 1'b0;
            wdata_q     <= '0;
            whilo_q     <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            align_q     <= 1'b0;
            bus_q       <= 1'b0;
            ram_req_q   <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_sel_q   <= '0;
            ram_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            off_q       <= off_d;
            valid_q     <= valid_d;
            wd_q        <= wd_d;
            wreg_q      <= wreg_d;
            wdata_q     <= wdata_d;
            whilo_q     <= whilo_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            align_q     <= align_d;
            bus_q       <= bus_d;
            ram_req_q   <= ram_req_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_sel_q   <= ram_sel_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

    // NOTE: every signal written in a combinational block gets a default
    // first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept_mem) begin
                    state_d = ACCESS;
                    cnt_d   = CNT_W'(1);
                end
            end
            ACCESS: begin
                if (ram_ack_i || timeout) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stall_req_o = accept_mem || ((state_q == ACCESS) && !ram_ack_i && !timeout);
        op_d        = op_q;
        off_d       = off_q;
        valid_d     = 1'b0;
        wd_d        = '0;
        wreg_d      = 1'b0;
        wdata_d     = '0;
        whilo_d     = 1'b0;
        hi_d        = '0;
        lo_d        = '0;
        align_d     = 1'b0;
        bus_d       = 1'b0;
        ram_req_d   = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = '0;
        ram_sel_d   = '0;
        ram_wdata_d = '0;
        unique case (state_q)
            IDLE: begin
                if (valid_i && !is_mem) begin
                    valid_d = 1'b1;
                    wd_d    = wd_i;
                    wreg_d  = wreg_i;
                    wdata_d = wdata_i;
                    whilo_d = whilo_i;
                    hi_d    = hi_i;
                    lo_d    = lo_i;
                end else if (valid_i && misaligned) begin
                    valid_d = 1'b1;
                    wd_d    = wd_i;
                    wdata_d = wdata_i;
                    align_d = 1'b1;
                end else if (accept_mem) begin
                    op_d       = mem_op_i;
                    off_d      = mem_addr_i[1:0];
                    ram_req_d  = 1'b1;
                    ram_we_d   = is_store;
                    ram_addr_d = {mem_addr_i[ADDR_W-1:2], 2'b00};
                    unique case (mem_op_i)
                        OP_SB: begin
                            ram_sel_d   = 4'b0001 << mem_addr_i[1:0];
                            ram_wdata_d = {4{mem_sdata_i[7:0]}};
                        end
                        OP_SH: begin
                            ram_sel_d   = mem_addr_i[1] ? 4'b1100 : 4'b0011;
                            ram_wdata_d = {2{mem_sdata_i[15:0]}};
                        end
                        OP_SW: begin
                            ram_sel_d   = 4'b1111;
                            ram_wdata_d = mem_sdata_i;
                        end
                        default: ram_sel_d = 4'b1111;
                    endcase
                end
            end
            ACCESS: begin
                if (ram_ack_i) begin
                    valid_d = 1'b1;
                    wd_d    = wd_i;
                    wreg_d  = wreg_i;
                    whilo_d = whilo_i;
                    hi_d    = hi_i;
                    lo_d    = lo_i;
                    unique case (op_q)
                        OP_LB:   wdata_d = {{24{load_byte[7]}}, load_byte};
                        OP_LBU:  wdata_d = {24'b0, load_byte};
                        OP_LH:   wdata_d = {{16{load_half[15]}}, load_half};
                        OP_LHU:  wdata_d = {16'b0, load_half};
                        OP_LW:   wdata_d = ram_rdata_i;
                        default: wdata_d = wdata_i;
                    endcase
                end else if (timeout) begin
                    valid_d = 1'b1;
                    wd_d    = wd_i;
                    bus_d   = 1'b1;
                end else begin
                    ram_req_d   = ram_req_q;
                    ram_we_d    = ram_we_q;
                    ram_addr_d  = ram_addr_q;
                    ram_sel_d   = ram_sel_q;
                    ram_wdata_d = ram_wdata_q;
                end
            end
            default: ;
        endcase
    end

    assign valid_o     = valid_q;
    assign wd_o        = wd_q;
    assign wreg_o      = wreg_q;
    assign wdata_o     = wdata_q;
    assign whilo_o     = whilo_q;
    assign hi_o        = hi_q;
    assign lo_o        = lo_q;
    assign align_err_o = align_q;
    assign bus_err_o   = bus_q;
    assign ram_req_o   = ram_req_q;
    assign ram_we_o    = ram_we_q;
    assign ram_addr_o  = ram_addr_q;
    assign ram_sel_o   = ram_sel_q;
    assign ram_wdata_o = ram_wdata_q;

endmodule
